aud_codec_i2s_master: RTL

Codec-side end of the WM8731 digital audio interface, running in I2S master mode. It generates BCLK, ADCLRCK and DACLRCK, serializes ADC stereo samples onto ADCDAT, and deserializes DACDAT into parallel stereo words. Its use is as a synthesizable codec stand-in for loopback/bring-up and as the partner model for AudRecorder/AudPlayer verification.

---
 rtl/aud_codec_i2s_master.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/aud_codec_i2s_master.sv
// WM8731-style I2S master codec stand-in: BCLK/LRCK generation, ADC serializer, DAC deserializer.
// Optional macro AUD_I2S_UNDERRUN_HOLD_EN: on underrun resend the previous pair instead of zeros.
module aud_codec_i2s_master #(
   parameter int BCLK_DIV = 2,
   parameter int DATA_W   = 16,
   parameter int SLOT_W   = 32
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_en,
   input  logic [DATA_W-1:0] i_adc_left,
   input  logic [DATA_W-1:0] i_adc_right,
   input  logic              i_adc_valid,
   output logic              o_adc_ready,
   output logic              o_bclk,
   output logic              o_adclrck,
   output logic              o_daclrck,
   output logic              o_adcdat,
   input  logic              i_dacdat,
   output logic [DATA_W-1:0] o_dac_left,
   output logic [DATA_W-1:0] o_dac_right,
   output logic              o_dac_valid,
   output logic              o_underrun
);

   localparam int DW = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;
   localparam int PW = $clog2(SLOT_W);
   localparam logic [DW-1:0] DIV_LAST = DW'(BCLK_DIV - 1);
   localparam logic [PW-1:0] P_LAST   = PW'(SLOT_W - 1);
   localparam logic [PW-1:0] P_DATA   = PW'(DATA_W);

   logic [DW-1:0]     div_cnt;
   logic [PW-1:0]     bit_pos;
   logic              chan;
   logic              run;
   logic              hold_full;
   logic [DATA_W-1:0] hold_l, hold_r;
   logic [DATA_W-1:0] sh_l, sh_r;
   logic [DATA_W-1:0] cap_l, cap_r;
`ifdef AUD_I2S_UNDERRUN_HOLD_EN
   logic [DATA_W-1:0] last_l, last_r;
`endif

   logic tick, bclk_fall, bclk_rise, frame_start, accept, load_full;

   // The first enabled cycle only loads the frame; the divider starts one cycle later
   // so that p=0 of the first slot lasts exactly one BCLK period.
   assign tick        = run && (div_cnt == DIV_LAST);
   assign bclk_fall   = tick & o_bclk;
   assign bclk_rise   = tick & ~o_bclk;
   assign frame_start = i_en & (~run | (bclk_fall & (bit_pos == P_LAST) & chan));
   assign accept      = i_adc_valid & o_adc_ready;
   assign load_full   = frame_start & hold_full;

   assign o_adc_ready = ~hold_full;
   assign o_adclrck   = chan;
   assign o_daclrck   = chan;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         hold_full <= 1'b0;
         hold_l    <= '0;
         hold_r    <= '0;
      end else begin
         if (accept) begin
            hold_l    <= i_adc_left;
            hold_r    <= i_adc_right;
            hold_full <= 1'b1;
         end else if (load_full) begin
            hold_full <= 1'b0;
         end
      end
   end

`ifdef AUD_I2S_UNDERRUN_HOLD_EN
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         last_l <= '0;
         last_r <= '0;
      end else if (load_full) begin
         last_l <= hold_l;
         last_r <= hold_r;
      end
   end
`endif

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         div_cnt     <= '0;
         bit_pos     <= '0;
         chan        <= 1'b0;
         run         <= 1'b0;
         o_bclk      <= 1'b0;
         o_adcdat    <= 1'b0;
         o_dac_valid <= 1'b0;
         o_underrun  <= 1'b0;
         sh_l        <= '0;
         sh_r        <= '0;
         cap_l       <= '0;
         cap_r       <= '0;
         o_dac_left  <= '0;
         o_dac_right <= '0;
      end else if (!i_en) begin
         div_cnt     <= '0;
         bit_pos     <= '0;
         chan        <= 1'b0;
         run         <= 1'b0;
         o_bclk      <= 1'b0;
         o_adcdat    <= 1'b0;
         o_dac_valid <= 1'b0;
         o_underrun  <= 1'b0;
         cap_l       <= '0;
         cap_r       <= '0;
      end else begin
         run         <= 1'b1;
         o_dac_valid <= 1'b0;
         o_underrun  <= 1'b0;
         if (run) div_cnt <= tick ? '0 : div_cnt + 1'b1;
         if (tick) o_bclk <= ~o_bclk;

         if (frame_start) begin
            o_underrun <= ~hold_full;
            if (hold_full) begin
               sh_l <= hold_l;
               sh_r <= hold_r;
            end else begin
`ifdef AUD_I2S_UNDERRUN_HOLD_EN
               sh_l <= last_l;
               sh_r <= last_r;
`else
               sh_l <= '0;
               sh_r <= '0;
`endif
            end
         end

         // One-bit I2S delay: slot bit p=0 is idle, the sample occupies p=1..DATA_W.
         if (bclk_fall) begin
            if (bit_pos == P_LAST) begin
               bit_pos  <= '0;
               chan     <= ~chan;
               o_adcdat <= 1'b0;
            end else begin
               bit_pos <= bit_pos + 1'b1;
               if (bit_pos < P_DATA) begin
                  if (chan) begin
                     o_adcdat <= sh_r[DATA_W-1];
                     sh_r     <= sh_r << 1;
                  end else begin
                     o_adcdat <= sh_l[DATA_W-1];
                     sh_l     <= sh_l << 1;
                  end
               end else begin
                  o_adcdat <= 1'b0;
               end
            end
         end

         if (bclk_rise && (bit_pos != '0) && (bit_pos <= P_DATA)) begin
            if (chan) cap_r <= {cap_r[DATA_W-2:0], i_dacdat};
            else      cap_l <= {cap_l[DATA_W-2:0], i_dacdat};
            if (chan && (bit_pos == P_DATA)) begin
               o_dac_left  <= cap_l;
               o_dac_right <= {cap_r[DATA_W-2:0], i_dacdat};
               o_dac_valid <= 1'b1;
            end
         end
      end
   end

endmodule
